// File: rtl/vga_sync_rx.sv
// Recovers pixel column/row and a visible flag from active-low hsync/vsync,
// and reports lock once sync edges repeatedly land where the mode expects.
module vga_sync_rx #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] column,
  output logic [9:0] row,
  output logic       visible,
  output logic       locked
);

  localparam int unsigned CW      = 10;
  localparam int unsigned H_WHOLE = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_WHOLE = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS      = H_VISIBLE + H_FRONT;
  localparam int unsigned HE      = HS + H_SYNC;
  localparam int unsigned VS      = V_VISIBLE + V_FRONT;
  localparam int unsigned H_TO    = 2 * H_WHOLE;
  localparam int unsigned TW      = $clog2(H_TO);

  logic          hs_q;
  logic          vs_q;
  logic [1:0]    h_cnt;
  logic [1:0]    v_cnt;
  logic [TW-1:0] h_timer;
  logic [1:0]    v_wraps;

  logic          h_fall;
  logic          h_rise;
  logic          v_fall;
  logic          col_end;
  logic          row_end;
  logic          row_wrap;
  logic          h_timeout;
  logic [CW-1:0] column_n;
  logic [CW-1:0] row_n;
  logic [1:0]    h_cnt_n;
  logic [1:0]    v_cnt_n;
  logic [TW-1:0] h_timer_n;
  logic [1:0]    v_wraps_n;
  logic          locked_n;
  logic          visible_n;

  assign h_fall  = !hsync && hs_q;
  assign h_rise  = hsync && !hs_q;
  assign v_fall  = !vsync && vs_q;
  assign col_end = (column == CW'(H_WHOLE - 1));
  assign row_end = (row == CW'(V_WHOLE - 1));

  // Position counters: free-running, realigned on every sync falling edge.
  always_comb begin
    column_n = col_end ? '0 : column + CW'(1);
    row_n    = row;
    row_wrap = 1'b0;
    if (h_fall) begin
      column_n = CW'(HS);
    end
    if (v_fall) begin
      row_n = CW'(VS);
    end else if (!h_fall && col_end) begin
      if (row_end) begin
        row_n    = '0;
        row_wrap = 1'b1;
      end else begin
        row_n = row + CW'(1);
      end
    end
  end

  // Horizontal match counter with a two-line watchdog on hsync falls.
  always_comb begin
    h_timeout = !h_fall && (h_timer == TW'(H_TO - 1));
    h_timer_n = h_timer;
    if (h_fall) begin
      h_timer_n = '0;
    end else if (!h_timeout) begin
      h_timer_n = h_timer + TW'(1);
    end

    h_cnt_n = h_cnt;
    if (h_fall) begin
      if (column == CW'(HS - 1)) begin
        h_cnt_n = (h_cnt == 2'd2) ? 2'd2 : h_cnt + 2'd1;
      end else begin
        h_cnt_n = 2'd0;
      end
    end else if (h_rise && (column != CW'(HE - 1))) begin
      h_cnt_n = 2'd0;
    end
    if (h_timeout) begin
      h_cnt_n = 2'd0;
    end
  end

  // Vertical match counter; two row wraps with no vsync fall drop it.
  always_comb begin
    v_wraps_n = v_wraps;
    v_cnt_n   = v_cnt;
    if (v_fall) begin
      v_wraps_n = 2'd0;
      if ((row == CW'(VS - 1)) && col_end) begin
        v_cnt_n = (v_cnt == 2'd2) ? 2'd2 : v_cnt + 2'd1;
      end else begin
        v_cnt_n = 2'd0;
      end
    end else if (row_wrap) begin
      v_wraps_n = (v_wraps == 2'd2) ? 2'd2 : v_wraps + 2'd1;
      if (v_wraps != 2'd0) begin
        v_cnt_n = 2'd0;
      end
    end
  end

  assign locked_n  = (h_cnt_n == 2'd2) && (v_cnt_n == 2'd2);
  assign visible_n = locked_n && (column_n < CW'(H_VISIBLE)) && (row_n < CW'(V_VISIBLE));

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      column  <= '0;
      row     <= '0;
      h_cnt   <= 2'd0;
      v_cnt   <= 2'd0;
      h_timer <= '0;
      v_wraps <= 2'd0;
      locked  <= 1'b0;
      visible <= 1'b0;
    end else begin
      hs_q    <= hsync;
      vs_q    <= vsync;
      column  <= column_n;
      row     <= row_n;
      h_cnt   <= h_cnt_n;
      v_cnt   <= v_cnt_n;
      h_timer <= h_timer_n;
      v_wraps <= v_wraps_n;
      locked  <= locked_n;
      visible <= visible_n;
    end
  end

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx on a reduced 40x20 mode driven by a
// behavioural sync generator; expected outputs are the generator delayed one cycle.
module tb_vga_sync_rx;

  localparam int HV = 20, HF = 4, HSY = 6, HB = 10;
  localparam int VV = 12, VF = 3, VSY = 2, VB = 3;
  localparam int HW = HV + HF + HSY + HB;  // 40
  localparam int VW = VV + VF + VSY + VB;  // 20
  localparam int HS = HV + HF;             // 24
  localparam int HE = HS + HSY;            // 30
  localparam int VS = VV + VF;             // 15

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hsync = 1'b1;
  logic       vsync = 1'b1;
  logic [9:0] column;
  logic [9:0] row;
  logic       visible;
  logic       locked;

  int checks = 0;
  int errors = 0;

  // generator state; scol/srow hold the position of the last driven sample
  int   gcol = 0, grow = 0, scol = 0, srow = 0;
  int   nvf = 0, stall = 0, hwhole_g = HW, hs_off = 0;
  logic force_hi = 1'b0, short_p = 1'b0;
  logic last_hs = 1'b1, last_vs = 1'b1, hf = 1'b0, hr = 1'b0;

  vga_sync_rx #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB)
  ) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
    .column(column), .row(row), .visible(visible), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drive one generator sample, clock it in, then advance the generator.
  task automatic gtick();
    logic hs, vs;
    hs = !(gcol >= HS + hs_off && gcol < HE + hs_off);
    if (force_hi) hs = 1'b1;
    if (short_p && gcol >= HS + 4) hs = 1'b1;
    vs = !(grow >= VS && grow < VS + VSY);
    hf = !hs && last_hs;
    hr = hs && !last_hs;
    if (!vs && last_vs) nvf++;
    last_hs = hs;
    last_vs = vs;
    scol = gcol;
    srow = grow;
    hsync = hs;
    vsync = vs;
    @(posedge clk);
    #1;
    if (stall > 0) begin
      stall--;
    end else begin
      gcol++;
      if (gcol == hwhole_g) begin
        gcol = 0;
        grow = (grow == VW - 1) ? 0 : grow + 1;
      end
    end
  endtask

  task automatic rtick();
    reset = 1'b1;
    gtick();
    reset = 1'b0;
    last_hs = 1'b1;
    last_vs = 1'b1;
    nvf = 0;
  endtask

  task automatic wait_hf(input string tag);
    int b;
    b = 0;
    do begin
      gtick();
      b++;
    end while (!hf && b < 2 * HW);
    check(tag, 32'(hf), 32'd1);
  endtask

  task automatic wait_lock(input string tag, input int budget);
    int b;
    b = 0;
    while (locked !== 1'b1 && b < budget) begin
      gtick();
      b++;
    end
    check(tag, 32'(locked), 32'd1);
  endtask

  // Lock is expected exactly from the sample carrying the third vsync fall.
  task automatic acquire(input string tag);
    int b;
    b = 0;
    do begin
      gtick();
      check({tag, "_lock"}, 32'(locked), 32'(nvf >= 3));
      check({tag, "_vis"}, 32'(visible), 32'(nvf >= 3 && scol < HV && srow < VV));
      b++;
    end while (nvf < 3 && b < 4 * HW * VW);
    check({tag, "_budget"}, 32'(nvf >= 3), 32'd1);
  endtask

  initial begin
    int b;

    rtick();
    check("rst_col", 32'(column), 32'd0);
    check("rst_row", 32'(row), 32'd0);
    check("rst_vis", 32'(visible), 32'd0);
    check("rst_lock", 32'(locked), 32'd0);

    // start the stream mid-frame so the first edges mismatch
    gcol = 7;
    grow = 5;
    acquire("acq");

    for (int i = 0; i < HW * VW; i++) begin
      gtick();
      check("frm_col", 32'(column), 32'(scol));
      check("frm_row", 32'(row), 32'(srow));
      check("frm_vis", 32'(visible), 32'(scol < HV && srow < VV));
      check("frm_lock", 32'(locked), 32'd1);
    end

    // missing hsync: lock drops 2*HW cycles after the last fall
    wait_hf("hold_sync");
    for (int k = 1; k <= 100; k++) begin
      force_hi = (k >= 20);
      gtick();
      check("hold_lock", 32'(locked), 32'(k < 2 * HW));
      check("hold_col", 32'(column), 32'(scol));
    end
    force_hi = 1'b0;
    wait_lock("hold_relock", 4 * HW);

    // 5-cycle phase shift of the whole stream
    b = 0;
    do begin
      gtick();
      b++;
    end while (!(scol == 2 && srow == 3) && b < 2 * HW * VW);
    stall = 5;
    b = 0;
    do begin
      gtick();
      if (!hf) check("dly_pre", 32'(locked), 32'd1);
      b++;
    end while (!hf && b < 2 * HW);
    check("dly_drop", 32'(locked), 32'd0);
    check("dly_col", 32'(column), 32'(HS));
    wait_hf("dly_hf1");
    check("dly_l1", 32'(locked), 32'd0);
    check("dly_col1", 32'(column), 32'(scol));
    wait_hf("dly_hf2");
    check("dly_l2", 32'(locked), 32'd1);

    // short hsync pulse: rise 2 cycles early
    wait_hf("short_sync");
    short_p = 1'b1;
    b = 0;
    do begin
      gtick();
      if (!hr) check("short_pre", 32'(locked), 32'd1);
      b++;
    end while (!hr && b < HW);
    check("short_drop", 32'(locked), 32'd0);
    short_p = 1'b0;
    wait_lock("short_relock", 4 * HW);

    // reset while locked in the visible region
    b = 0;
    do begin
      gtick();
      b++;
    end while (!(gcol == 15 && grow == 10) && b < 2 * HW * VW);
    check("mid_pre_lock", 32'(locked), 32'd1);
    check("mid_pre_vis", 32'(visible), 32'd1);
    rtick();
    check("mid_col", 32'(column), 32'd0);
    check("mid_row", 32'(row), 32'd0);
    check("mid_lock", 32'(locked), 32'd0);
    check("mid_vis", 32'(visible), 32'd0);
    acquire("reacq");

    // line one pixel too long: never locks
    rtick();
    hwhole_g = HW + 1;
    hs_off = 1;
    gcol = 0;
    grow = 0;
    for (int i = 0; i < 4 * (HW + 1) * VW; i++) begin
      gtick();
      check("long_lock", 32'(locked), 32'd0);
      check("long_vis", 32'(visible), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
